// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_pkg;

   localparam int DEMUX_N     = 4;
   localparam int DEMUX_W     = 8;
   localparam int DEMUX_CNT_W = 8;

   // True when a channel select addresses an existing output channel.
   function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
      return (sel < n);
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
// Latency: a pushed word is presented on data/full the cycle after the push edge.
// Backpressure: push wins over pop on the same edge (pass-through refill); owner gates push.
module demux_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         full,
   output logic [W-1:0] data
);

   // Slot state: reset clears, push loads, pop empties while holding the last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         data <= '0;
      end else if (push) begin
         full <= 1'b1;
         data <= push_data;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux: steers each accepted word into the selected channel slot.
// Latency: one cycle from input acceptance to out_valid on the selected channel.
// Backpressure: ip_ready follows the selected slot (empty or draining); out-of-range selects always accepted and dropped.
module stream_demux_1ton
   import demux_pkg::*;
#(
   parameter  int N     = DEMUX_N,
   parameter  int W     = DEMUX_W,
   parameter  int CNT_W = DEMUX_CNT_W,
   localparam int SEL_W = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [W-1:0]        ip,
   input  logic [SEL_W-1:0]    sel,
   input  logic                ip_valid,
   output logic                ip_ready,
   output logic [N-1:0][W-1:0] out,
   output logic [N-1:0]        out_valid,
   input  logic [N-1:0]        out_ready,
   output logic [CNT_W-1:0]    drop_count
);

   logic [N-1:0]        full;
   logic [N-1:0][W-1:0] data;
   logic [N-1:0]        push;
   logic [N-1:0]        pop;
   logic                in_range;
   logic                drop;

   assign in_range = sel_in_range(32'(sel), N);
   assign pop      = full & out_ready;
   assign drop     = ip_valid && !in_range;

   // Ready mux and push decode; the loop compare avoids indexing past N on a bad select.
   always_comb begin
      ip_ready = 1'b1;
      push     = '0;
      if (in_range) begin
         for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
               ip_ready = !full[k] || out_ready[k];
               push[k]  = ip_valid && (!full[k] || out_ready[k]);
            end
         end
      end
   end

   // Saturating count of words discarded for an out-of-range select.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= '0;
      end else if (drop && (drop_count != {CNT_W{1'b1}})) begin
         drop_count <= drop_count + 1'b1;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slot
      demux_slot #(
         .W (W)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .push      (push[k]),
         .push_data (ip),
         .pop       (pop[k]),
         .full      (full[k]),
         .data      (data[k])
      );
   end

   assign out       = data;
   assign out_valid = full;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed and scoreboard-checked stimulus for the 1-to-N stream demux.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_stream_demux_1ton;

   logic clk = 1'b0;
   logic rst;

   // Main instance: N=4, W=8, CNT_W=8.
   logic [7:0]       ip;
   logic [1:0]       sel;
   logic             ip_valid;
   logic             ip_ready;
   logic [3:0][7:0]  out;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [7:0]       drop_count;

   // Drop instance: N=3, W=8, CNT_W=2.
   logic [7:0]       d3_ip;
   logic [1:0]       d3_sel;
   logic             d3_ip_valid;
   logic             d3_ip_ready;
   logic [2:0][7:0]  d3_out;
   logic [2:0]       d3_out_valid;
   logic [2:0]       d3_out_ready;
   logic [1:0]       d3_drop_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] mq [4][$];

   always #5 clk = ~clk;

   stream_demux_1ton #(.N(4), .W(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ip         (ip),
      .sel        (sel),
      .ip_valid   (ip_valid),
      .ip_ready   (ip_ready),
      .out        (out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .drop_count (drop_count)
   );

   stream_demux_1ton #(.N(3), .W(8), .CNT_W(2)) dut3 (
      .clk        (clk),
      .rst        (rst),
      .ip         (d3_ip),
      .sel        (d3_sel),
      .ip_valid   (d3_ip_valid),
      .ip_ready   (d3_ip_ready),
      .out        (d3_out),
      .out_valid  (d3_out_valid),
      .out_ready  (d3_out_ready),
      .drop_count (d3_drop_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_word;
      logic       exp_rdy;
      logic [3:0] acc;

      rst          = 1'b1;
      ip_valid     = 1'b1;
      ip           = 8'hA5;
      sel          = 2'd1;
      out_ready    = 4'b0000;
      d3_ip        = 8'h00;
      d3_sel       = 2'd0;
      d3_ip_valid  = 1'b0;
      d3_out_ready = 3'b000;

      // Reset held two cycles with a valid word pending.
      tick();
      tick();
      chk("reset_out_valid", 64'(out_valid), 64'h0);
      chk("reset_out", 64'(out), 64'h0);
      chk("reset_drop_count", 64'(drop_count), 64'h0);
      chk("reset_d3_drop_count", 64'(d3_drop_count), 64'h0);
      rst = 1'b0;
      #1;
      chk("post_reset_ip_ready", 64'(ip_ready), 64'h1);
      tick();
      chk("post_reset_out_valid", 64'(out_valid), 64'h2);
      chk("post_reset_out", 64'(out), 64'h0000A500);
      ip_valid  = 1'b0;
      out_ready = 4'b1111;
      tick();
      chk("drain_out_valid", 64'(out_valid), 64'h0);

      // Steering into four blocked channels.
      out_ready = 4'b0000;
      ip_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         ip  = 8'(8'h11 * (i + 1));
         #1;
         chk("steer_ip_ready", 64'(ip_ready), 64'h1);
         tick();
      end
      chk("steer_out_valid", 64'(out_valid), 64'hF);
      chk("steer_out", 64'(out), 64'h44332211);
      sel = 2'd2;
      ip  = 8'h55;
      #1;
      chk("full_ip_ready", 64'(ip_ready), 64'h0);
      tick();
      chk("full_out2_held", 64'(out[2]), 64'h33);
      chk("full_out_valid", 64'(out_valid), 64'hF);

      // Back-to-back stream into channel 3 with its consumer always ready.
      out_ready = 4'b1000;
      sel       = 2'd3;
      for (int i = 0; i < 10; i++) begin
         ip = 8'(i);
         #1;
         chk("b2b_ip_ready", 64'(ip_ready), 64'h1);
         tick();
         chk("b2b_out3", 64'(out[3]), 64'(i));
         chk("b2b_out_valid3", 64'(out_valid[3]), 64'h1);
      end
      ip_valid = 1'b0;
      tick();
      chk("b2b_drained", 64'(out_valid), 64'h7);
      chk("b2b_others_held", 64'(out[2:0]), 64'h332211);

      // Simultaneous pop and push on channel 0.
      out_ready = 4'b0001;
      ip_valid  = 1'b1;
      sel       = 2'd0;
      ip        = 8'hC3;
      tick();
      chk("pp_load_c3", 64'(out[0]), 64'hC3);
      ip = 8'h3C;
      #1;
      chk("pp_ip_ready", 64'(ip_ready), 64'h1);
      tick();
      chk("pp_out0", 64'(out[0]), 64'h3C);
      chk("pp_out_valid0", 64'(out_valid[0]), 64'h1);
      ip_valid  = 1'b0;
      out_ready = 4'b1111;
      tick();
      chk("pp_all_empty", 64'(out_valid), 64'h0);
      out_ready = 4'b0000;

      // Drops and saturation on the N=3, CNT_W=2 instance.
      d3_ip_valid = 1'b1;
      d3_sel      = 2'd3;
      for (int i = 0; i < 5; i++) begin
         d3_ip = 8'(8'hE0 + i);
         #1;
         chk("drop_ip_ready", 64'(d3_ip_ready), 64'h1);
         tick();
         chk("drop_count", 64'(d3_drop_count), 64'((i < 3) ? (i + 1) : 3));
         chk("drop_out_valid", 64'(d3_out_valid), 64'h0);
      end
      d3_sel = 2'd2;
      d3_ip  = 8'h7E;
      tick();
      chk("d3_inrange_valid", 64'(d3_out_valid), 64'h4);
      chk("d3_inrange_data", 64'(d3_out[2]), 64'h7E);
      chk("d3_count_kept", 64'(d3_drop_count), 64'h3);
      d3_ip_valid = 1'b0;

      // Random traffic against per-channel depth-1 queues.
      for (int c = 0; c < 1000; c++) begin
         ip_valid  = 1'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         ip        = 8'($urandom_range(0, 255));
         out_ready = 4'($urandom_range(0, 15));
         #1;
         exp_rdy = (mq[sel].size() == 0) || out_ready[sel];
         chk("rnd_ip_ready", 64'(ip_ready), 64'(exp_rdy));
         for (int k = 0; k < 4; k++) begin
            chk("rnd_out_valid", 64'(out_valid[k]), 64'(mq[k].size() != 0));
            if (mq[k].size() != 0) begin
               exp_word = mq[k][0];
               chk("rnd_out_data", 64'(out[k]), 64'(exp_word));
            end
         end
         for (int k = 0; k < 4; k++) begin
            if ((mq[k].size() != 0) && out_ready[k]) begin
               void'(mq[k].pop_front());
            end
         end
         acc = 4'b0000;
         if (ip_valid && exp_rdy) begin
            acc[sel] = 1'b1;
            mq[sel].push_back(ip);
         end
         tick();
      end
      ip_valid = 1'b0;
      chk("rnd_drop_count", 64'(drop_count), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_demux_1ton.md
# stream_demux_1toN

Registered 1-to-N stream demultiplexer with valid/ready handshake, the write-side counterpart of `Nto1_mux`. One input word plus a channel select is accepted per cycle and steered into a one-entry holding slot on the selected output channel. Each channel presents its word to its own consumer until that consumer takes it. Out-of-range selects are discarded and counted. The block sits where a shared producer fans out to N independent consumers.

## Interface
Parameters:
- `N`, 4, number of output channels; legal range 2..16.
- `W`, 8, data width in bits.
- `CNT_W`, 8, width of the drop counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ip`  in  W  input data word.
- `sel`  in  $clog2(N)  destination channel for `ip`.
- `ip_valid`  in  1  `ip`/`sel` are valid this cycle.
- `ip_ready`  out  1  block accepts the word this cycle.
- `out`  out  [N-1:0][W-1:0]  per-channel held data.
- `out_valid`  out  N  channel slot is full.
- `out_ready`  in  N  channel consumer takes the word this cycle.
- `drop_count`  out  CNT_W  saturating count of words dropped for an out-of-range `sel`.

## Operation
- Input transfer: a word is accepted when `ip_valid && ip_ready` at a rising edge.
- Output transfer on channel k: the word is taken when `out_valid[k] && out_ready[k]` at a rising edge.
- Each channel k has a one-entry slot holding `full[k]` and `data[k]`. `out_valid[k] = full[k]` and `out[k] = data[k]`.
- `ip_ready`:
  - For `sel < N`: `ip_ready = !full[sel] || out_ready[sel]`. This is a combinational path from `out_ready` to `ip_ready` and is permitted.
  - For `sel >= N`: `ip_ready = 1`. The word is dropped.
- `ip_ready` is computed regardless of `ip_valid`.
- Slot update per channel k, each edge, in priority order:
  - Input transfer with `sel == k`: `data[k] <= ip`, `full[k] <= 1`. This covers simultaneous output transfer on k (pass-through refill).
  - Otherwise, output transfer on k: `full[k] <= 0`. `data[k]` is held.
  - Otherwise: no change.
- Non-selected channels drain independently in the same cycle; all N may pop on one edge.
- Drop: an input transfer with `sel >= N` increments `drop_count` by 1.
  - `drop_count` saturates at 2^CNT_W-1 and never wraps.
  - Drops are only possible when N is not a power of two.
- `out[k]` is stable while `out_valid[k]=1 && out_ready[k]=0`.
- `sel` and `ip` are don't-care when `ip_valid=0`. No state changes in that case except drains.

## Timing
- Reset (`rst=1` at an edge): `full` = all 0, `data` = all 0, `drop_count` = 0. Hence `out_valid` = 0 and `out` = 0.
- Reset mid-operation discards any held words with no handshake.
- `ip_ready` during reset follows the combinational rule; after reset it is 1, since all slots are empty.
- Latency: a word accepted at edge t is visible on `out[sel]` with `out_valid[sel]=1` after edge t, i.e. in cycle t+1.
- Throughput: 1 word/cycle into a channel whose consumer holds `out_ready=1` continuously. Different channels are fully independent.
- Full slot with `out_ready[sel]=0`: `ip_ready=0`. The producer must hold `ip`/`sel`/`ip_valid` stable until accepted, per the standard valid/ready rule.

## Structure
- Shared package `demux_pkg`:
  - Default constants `DEMUX_N=4`, `DEMUX_W=8`, `DEMUX_CNT_W=8`.
  - Function `sel_in_range(sel, n)` for use by RTL and bench.
- Sub-module `demux_slot #(W)`: one-entry register with `push`, `push_data`, `pop`, `full`, `data`, `rst`. Instantiate it N times in a generate loop.
- The top level holds the `ip_ready` mux, the push decode, and the drop counter.

## Test plan
Parameters N=4, W=8 unless stated.
- Reset: assert `rst` 2 cycles with `ip_valid=1`, `ip=8'hA5`, `sel=1` → `out_valid=4'b0000`, `out` all 0, `drop_count=0`. One cycle after deassert `out_valid=4'b0010`, `out[1]=8'hA5`.
- Steering: `out_ready=4'b0000`; send `8'h11`→0, `8'h22`→1, `8'h33`→2, `8'h44`→3 → `out_valid=4'b1111`, `out=={44,33,22,11}`. A further word to sel 2 sees `ip_ready=0`, and `out[2]` stays `8'h33`.
- Back-to-back: `out_ready[3]=1`; stream 10 words `8'h00..8'h09` to sel 3 → `ip_ready=1` every cycle, and the consumer sees the same sequence in order, each one cycle after acceptance.
- Simultaneous pop/push: slot 0 holds `8'hC3`, `out_ready[0]=1`, push `8'h3C`→0 on the same edge → `ip_ready=1`, next cycle `out[0]=8'h3C`, `out_valid[0]=1`.
- Drop/saturation: N=3, CNT_W=2; send 5 words with `sel=3` → `ip_ready=1` each time, `drop_count` reads 1,2,3,3,3, and `out_valid` stays 0.
- Random: 1000 cycles of random `ip_valid`/`sel`/`out_ready` against a scoreboard of per-channel queues of depth 1 → no loss, no duplication, and order preserved.
